// File: rtl/mlp_dma_pkg.sv
// Shared types and constants for the MLP DMA read engine.
//   dma_state_e  : read-engine FSM states
//   WordBytes    : byte stride between consecutive memory words
//   fifo_entry_t : one buffered stream word (last flag + data), default 32-bit data
package mlp_dma_pkg;

  localparam int unsigned WordBytes = 4;
  localparam int unsigned DefDWidth = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GAP,
    DRAIN,
    FIN
  } dma_state_e;

  typedef struct packed {
    logic                 last;
    logic [DefDWidth-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/mlp_dma_fifo.sv
// Synchronous FIFO buffering read words for the stream side.
// Ports:
//   clk_i, rst_i       : clock, async active-high reset
//   push_i / din_i     : write an entry (ignored when full)
//   pop_i              : drop the head entry (ignored when empty)
//   flush_i            : discard all entries (wins over push/pop)
//   full_o, empty_o    : occupancy flags
//   count_o            : number of stored entries
//   head_o             : oldest entry
module mlp_dma_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [Width-1:0]       din_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o,
  output logic [Width-1:0]       head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < Depth; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din_i;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

endmodule

// File: rtl/mlp_dma_reader.sv
// Burst-read engine: issues sequential single-word reads on the shared memory
// data port and streams the returned words to the MLP datapath.
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   start_i, abort_i             : launch / cancel a transfer
//   base_addr_i, len_i           : byte base address (low 2 bits ignored), word count
//   busy_o, done_o               : engine active, completion pulse
//   dmem_*                       : memory request port (read-only use)
//   m_valid_o/m_ready_i/m_data_o/m_last_o : output word stream
module mlp_dma_reader
  import mlp_dma_pkg::*;
#(
  parameter int unsigned DWidth    = 32,
  parameter int unsigned LenWidth  = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [DWidth-1:0]   base_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                dmem_req_o,
  output logic                dmem_write_o,
  output logic [DWidth-1:0]   dmem_addr_o,
  output logic [DWidth-1:0]   dmem_wdata_o,
  input  logic                dmem_ready_i,
  input  logic [DWidth-1:0]   dmem_rdata_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [DWidth-1:0]   m_data_o,
  output logic                m_last_o
);

  localparam int unsigned CntW   = $clog2(FifoDepth) + 1;
  localparam int unsigned FWidth = DWidth + 1;

  dma_state_e          r_state;
  logic [DWidth-1:0]   r_addr;
  logic [LenWidth-1:0] r_remaining;
  logic                r_req;
  logic                r_busy;
  logic                r_done;

  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_full;
  logic                w_empty;
  logic                w_room;
  logic [CntW-1:0]     w_count;
  logic [FWidth-1:0]   w_din;
  logic [FWidth-1:0]   w_head;
  logic [DWidth-1:0]   w_aligned_base;

  assign w_aligned_base = base_addr_i & ~(DWidth'(WordBytes) - DWidth'(1));

  // A read data beat is accepted only while our own request is up and not being aborted.
  assign w_push  = (r_state == REQ) && r_req && dmem_ready_i && !abort_i && !w_full;
  assign w_pop   = !w_empty && m_ready_i;
  assign w_flush = abort_i && (r_state != IDLE);
  assign w_din   = {(r_remaining == LenWidth'(1)), dmem_rdata_i};

  // Space for one more word after this edge; no push can coincide with a fresh request decision.
  assign w_room  = (w_count - CntW'(w_pop)) < CntW'(FifoDepth);

  mlp_dma_fifo #(
    .Width (FWidth),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .din_i   (w_din),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count),
    .head_o  (w_head)
  );

  // Transfer control: state, address/remaining counters and registered handshake outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_req       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_flush) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_addr      <= w_aligned_base;
            r_remaining <= len_i;
            r_busy      <= 1'b1;
            if (len_i == '0) begin
              r_state <= FIN;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end
        end
        REQ: begin
          if (r_req) begin
            if (dmem_ready_i) begin
              r_req       <= 1'b0;
              r_addr      <= r_addr + DWidth'(WordBytes);
              r_remaining <= r_remaining - LenWidth'(1);
              r_state     <= (r_remaining == LenWidth'(1)) ? DRAIN : GAP;
            end
          end else begin
            // Stalled on a full FIFO: raise the request once a slot frees up.
            r_req <= w_room;
          end
        end
        GAP: begin
          r_state <= REQ;
          r_req   <= w_room;
        end
        DRAIN: begin
          if (w_pop && w_head[DWidth]) r_state <= FIN;
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign dmem_req_o   = r_req;
  assign dmem_addr_o  = r_addr;
  assign dmem_write_o = 1'b0;
  assign dmem_wdata_o = '0;
  assign m_valid_o    = !w_empty;
  assign m_data_o     = w_head[DWidth-1:0];
  assign m_last_o     = w_head[DWidth];

endmodule
